// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter (IDLE/ARM/SEND).
// Optional CR insertion before each LF: define UART_TX_FIFO_CRLF_EN.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ARM_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [CW-1:0] arm_cnt;

    logic          push;
    logic          launch;
    logic          pop;
    logic [7:0]    head;
    logic [7:0]    launch_data;
    logic [LW-1:0] level_next;

`ifdef UART_TX_FIFO_CRLF_EN
    logic cr_pending;
    logic insert_cr;
`endif

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        push        = wr_en && !full;
        launch      = (state == ST_IDLE) && !empty && !tx_busy;
        head        = mem[rd_ptr];
        pop         = launch;
        launch_data = head;
`ifdef UART_TX_FIFO_CRLF_EN
        insert_cr = (head == 8'h0A) && !cr_pending;
        if (insert_cr) begin
            pop         = 1'b0;
            launch_data = 8'h0D;
        end
`endif
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // NOTE: storage is not reset; the reset pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            state    <= ST_IDLE;
            arm_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level    <= level_next;
            // full tracks the new level so a back-to-back push is refused at once;
            // empty trails level by a cycle, giving the launch its two-edge latency.
            full     <= (level_next == LW'(DEPTH));
            empty    <= (level == '0);
            overflow <= wr_en && full;

            case (state)
                ST_IDLE: begin
                    tx_start <= 1'b0;
                    if (launch) begin
                        tx_data  <= launch_data;
                        tx_start <= 1'b1;
                        arm_cnt  <= '0;
                        state    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    tx_start <= 1'b0;
                    if (tx_busy) begin
                        arm_cnt <= '0;
                        state   <= ST_SEND;
                    end else if (arm_cnt == CW'(ARM_TIMEOUT - 1)) begin
                        // Transmitter never answered; the popped byte is abandoned.
                        arm_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        arm_cnt <= arm_cnt + CW'(1);
                    end
                end
                ST_SEND: begin
                    tx_start <= 1'b0;
                    if (!tx_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_CRLF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cr_pending <= 1'b0;
        end else if (launch && insert_cr) begin
            cr_pending <= 1'b1;
        end else if (pop) begin
            cr_pending <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences and
// randomized bursts compared against a byte-queue model and a transmitter model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    uart_tx_fifo #(.DEPTH(DEPTH), .ARM_TIMEOUT(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Transmitter model control: 0 = behavioural frame of frame_len cycles, 1 = busy tied high, 2 = tied low.
    int         busy_mode = 0;
    int         frame_len = 4;
    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_launch = 8'h00;

    typedef struct {
        logic       wr_en;
        logic [7:0] data;
        int         exp_level;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Expected wire bytes for one stored byte.
    task automatic expect_byte(input logic [7:0] b);
`ifdef UART_TX_FIFO_CRLF_EN
        if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(b);
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sent_q.size() >= exp_q.size() && !tx_busy) break;
        end
        tick(4);
    endtask

    task automatic compare_sent(input string name);
        check({name, "_count"}, sent_q.size(), exp_q.size());
        for (int i = 0; i < sent_q.size() && i < exp_q.size(); i++)
            check({name, "_byte"}, sent_q[i], exp_q[i]);
        sent_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        sent_q.delete();
        exp_q.delete();
    endtask

    // Transmitter model and launch monitor, both evaluated at the falling edge.
    initial begin
        int  rem;
        bit  pend;
        rem     = 0;
        pend    = 1'b0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_start === 1'b1) begin
                check("start_while_busy", tx_busy, 1'b0);
                sent_q.push_back(tx_data);
                last_launch = tx_data;
            end
            if (rst_n === 1'b1 && busy_mode == 0 && tx_busy)
                check("tx_data_stable", tx_data, last_launch);
            if (rst_n !== 1'b1) begin
                tx_busy     = 1'b0;
                rem         = 0;
                pend        = 1'b0;
                last_launch = 8'h00;
            end else if (busy_mode == 1) begin
                tx_busy = 1'b1;
            end else if (busy_mode == 2) begin
                tx_busy = 1'b0;
            end else if (pend) begin
                tx_busy = 1'b1;
                rem     = frame_len;
                pend    = 1'b0;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) tx_busy = 1'b0;
            end else begin
                tx_busy = 1'b0;
            end
            if (rst_n === 1'b1 && tx_start === 1'b1) pend = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        logic [7:0] b;

        // Vector table: busy held high, 17 pushes into a 16-entry FIFO, then one idle cycle.
        for (int i = 0; i < 17; i++) begin
            vecs[i].wr_en     = 1'b1;
            vecs[i].data      = 8'h10 + 8'(i);
            vecs[i].exp_level = (i + 1 > DEPTH) ? DEPTH : i + 1;
            vecs[i].exp_full  = (i + 1 >= DEPTH);
            vecs[i].exp_empty = (i == 0);
            vecs[i].exp_ovf   = (i == DEPTH);
        end
        vecs[17] = '{1'b0, 8'h00, DEPTH, 1'b1, 1'b0, 1'b0};

        wr_en   = 1'b0;
        wr_data = 8'h00;

        // 1: reset values
        rst_n = 1'b0;
        tick(2);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_level", level, 5'd0);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // 2: single byte latency and pulse width
        busy_mode = 0;
        frame_len = 20;
        push(8'h55);
        expect_byte(8'h55);
        check("t2_start_k", tx_start, 1'b0);
        tick();
        check("t2_start_k1", tx_start, 1'b0);
        check("t2_empty_k1", empty, 1'b0);
        tick();
        check("t2_start_k2", tx_start, 1'b1);
        check("t2_data_k2", tx_data, 8'h55);
        tick();
        check("t2_pulse_width", tx_start, 1'b0);
        wait_idle(200);
        compare_sent("t2_sent");
        check("t2_empty_after", empty, 1'b1);
        check("t2_level_after", level, 5'd0);

        // 3: three back-to-back bytes
        frame_len = 5;
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'hA1 + 8'(i);
            expect_byte(wr_data);
            tick();
        end
        wr_en = 1'b0;
        wait_idle(300);
        compare_sent("t3_sent");
        check("t3_level_after", level, 5'd0);

        // 4: fill to full with busy forced, overflow, then drain in order
        do_reset();
        busy_mode = 1;
        tick();
        foreach (vecs[i]) begin
            wr_en   = vecs[i].wr_en;
            wr_data = vecs[i].data;
            tick();
            check("t4_level", level, vecs[i].exp_level);
            check("t4_full", full, vecs[i].exp_full);
            check("t4_empty", empty, vecs[i].exp_empty);
            check("t4_overflow", overflow, vecs[i].exp_ovf);
        end
        wr_en = 1'b0;
        check("t4_no_launch_while_busy", sent_q.size(), 0);
        for (int i = 0; i < DEPTH; i++) expect_byte(8'h10 + 8'(i));
        frame_len = 2;
        busy_mode = 0;
        wait_idle(2000);
        compare_sent("t4_drain");
        check("t4_level_after", level, 5'd0);
        check("t4_full_after", full, 1'b0);

        // 5: LF handling
        frame_len = 3;
        push(8'h41);
        expect_byte(8'h41);
        push(8'h0A);
        expect_byte(8'h0A);
        wait_idle(300);
        compare_sent("t5_sent");
        check("t5_level_after", level, 5'd0);

        // 6: transmitter never answers -> timeout back to IDLE, no retry
        busy_mode = 2;
        tick(2);
        push(8'h33);
        expect_byte(8'h33);
        cyc = 0;
        while (tx_start !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        check("t6_first_start", tx_start, 1'b1);
        push(8'h34);
        expect_byte(8'h34);
        cyc = 1;
        while (tx_start !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t6_relaunch_gap", cyc, 9);
        tick(12);
        compare_sent("t6_sent");
        check("t6_level_after", level, 5'd0);

        // 7: reset in the middle of a frame with 5 bytes queued
        do_reset();
        busy_mode = 0;
        frame_len = 40;
        for (int i = 0; i < 6; i++) push(8'h70 + 8'(i));
        cyc = 0;
        while (!tx_busy && cyc < 20) begin
            tick();
            cyc++;
        end
        tick(2);
        check("t7_busy_before", tx_busy, 1'b1);
        check("t7_level_before", level, 5'd5);
        rst_n = 1'b0;
        tick();
        check("t7_level", level, 5'd0);
        check("t7_empty", empty, 1'b1);
        check("t7_full", full, 1'b0);
        check("t7_tx_start", tx_start, 1'b0);
        check("t7_tx_data", tx_data, 8'h00);
        check("t7_overflow", overflow, 1'b0);
        tick();
        rst_n = 1'b1;
        tick(6);
        exp_q.push_back(8'h70);
        compare_sent("t7_sent");
        check("t7_level_after", level, 5'd0);

        // Randomized bursts against the byte-queue model
        for (int burst = 0; burst < 6; burst++) begin
            frame_len = $urandom_range(1, 6);
            n = $urandom_range(1, 10);
            for (int j = 0; j < n; j++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
                push(b);
                expect_byte(b);
                check("rnd_overflow", overflow, 1'b0);
                tick($urandom_range(0, 3));
            end
            wait_idle(2000);
            compare_sent("rnd_sent");
            check("rnd_level_after", level, 5'd0);
            check("rnd_empty_after", empty, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
